// File: rtl/stripes_pkg.sv
// Shared types and helpers for the Stripes bit-serial datapath.
// Widths are passed as ints so one package serves every tile configuration.
package stripes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FINAL = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  // Wide enough for any accumulator this datapath can produce.
  localparam int SAT_W = 128;
  localparam logic signed [SAT_W-1:0] SAT_ONE = 128'sd1;

  function automatic int acc_width(input int n, input int ti);
    return 2 * n + $clog2(ti) + 1;
  endfunction

  // Clamp a sign-extended value into the signed n-bit range.
  function automatic logic signed [SAT_W-1:0] sat_signed(input logic signed [SAT_W-1:0] v,
                                                         input int n);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_ONE <<< (n - 1)) - SAT_ONE;
    lo = -hi - SAT_ONE;
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

  // A zero or oversized precision means full width.
  function automatic int clamp_prec(input int p, input int n);
    return ((p == 32'sd0) || (p > n)) ? n : p;
  endfunction

endpackage

// File: rtl/serial_ip_lane.sv
// One window of the bit-serial inner product: gated adder tree, MSB-first
// shift-accumulator, and the final sum/max merge with saturation.
module serial_ip_lane
  import stripes_pkg::*;
#(
  parameter int N  = 16,
  parameter int Ti = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear_i,
  input  logic            shift_i,
  input  logic            final_i,
  input  logic            max_i,
  input  logic [Ti*N-1:0] syn_i,
  input  logic [N-1:0]    nbout_i,
  input  logic [Ti-1:0]   bits_i,
  output logic [N-1:0]    res_o
);

  localparam int ACC_W = acc_width(N, Ti);
  localparam logic signed [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] tree_s, nb_s, merge_s;
  logic signed [SAT_W-1:0] sat_s;
  logic        [N-1:0]     res_q, res_d;

  // Sum of the synapses selected by this bit slice.
  always_comb begin
    tree_s = ACC_ZERO;
    for (int i = 0; i < Ti; i++) begin
      tree_s = tree_s + (bits_i[i] ? ACC_W'($signed(syn_i[i*N +: N])) : ACC_ZERO);
    end
  end

  // Accumulator update and final merge with nbout.
  always_comb begin
    nb_s = ACC_W'($signed(nbout_i));
    if (max_i) begin
      merge_s = (acc_q > nb_s) ? acc_q : nb_s;
    end else begin
      merge_s = acc_q + nb_s;
    end
    sat_s = sat_signed(SAT_W'(merge_s), N);

    if (clear_i) begin
      acc_d = ACC_ZERO;
    end else if (shift_i) begin
      acc_d = (acc_q <<< 1) + tree_s;
    end else begin
      acc_d = acc_q;
    end

    if (final_i) begin
      res_d = sat_s[N-1:0];
    end else begin
      res_d = res_q;
    end
  end

  // Accumulator and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= ACC_ZERO;
      res_q <= {N{1'b0}};
    end else begin
      acc_q <= acc_d;
      res_q <= res_d;
    end
  end

  assign res_o = res_q;

endmodule

// File: rtl/serial_ip_tile.sv
// Multi-window bit-serial inner-product tile: FSM, bit counter, operand
// latches and valid/ready handshake around Tw serial_ip_lane instances.
module serial_ip_tile
  import stripes_pkg::*;
#(
  parameter int N  = 16,
  parameter int Ti = 16,
  parameter int Tw = 16,
  parameter int PW = $clog2(N) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  output logic             o_ready,
  input  logic [PW-1:0]    i_precision,
  input  logic             i_max,
  input  logic [Ti*N-1:0]  i_synapses,
  input  logic [Tw*N-1:0]  i_nbout,
  input  logic             i_bit_valid,
  input  logic [Tw*Ti-1:0] i_neurons,
  output logic             o_valid,
  input  logic             i_out_ready,
  output logic [Tw*N-1:0]  o_nfu2_out
);

  localparam logic [PW-1:0] CNT_ONE = {{(PW-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [PW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     prec_q, prec_d;
  logic              max_q, max_d;
  logic [Ti*N-1:0]   syn_q, syn_d;
  logic [Tw*N-1:0]   nbout_q, nbout_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic              start_s, shift_s, final_s;

  assign start_s = (state_q == ST_IDLE) && i_start;
  assign shift_s = (state_q == ST_SHIFT) && i_bit_valid;
  assign final_s = (state_q == ST_FINAL);

  // Next-state, counter and operand-latch logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prec_d  = prec_q;
    max_d   = max_q;
    syn_d   = syn_q;
    nbout_d = nbout_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_SHIFT;
          cnt_d   = {PW{1'b0}};
          prec_d  = PW'(clamp_prec(int'(i_precision), N));
          max_d   = i_max;
          syn_d   = i_synapses;
          nbout_d = i_nbout;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (i_bit_valid) begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_d == prec_q) begin
            state_d = ST_FINAL;
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_FINAL: state_d = ST_OUT;
      ST_OUT: begin
        if (i_out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
    valid_d = (state_d == ST_OUT);
  end

  // Control and operand registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= {PW{1'b0}};
      prec_q  <= {PW{1'b0}};
      max_q   <= 1'b0;
      syn_q   <= {(Ti*N){1'b0}};
      nbout_q <= {(Tw*N){1'b0}};
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prec_q  <= prec_d;
      max_q   <= max_d;
      syn_q   <= syn_d;
      nbout_q <= nbout_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;

  for (genvar w = 0; w < Tw; w++) begin : g_lane
    serial_ip_lane #(
      .N  (N),
      .Ti (Ti)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .clear_i (start_s),
      .shift_i (shift_s),
      .final_i (final_s),
      .max_i   (max_q),
      .syn_i   (syn_q),
      .nbout_i (nbout_q[w*N +: N]),
      .bits_i  (i_neurons[w*Ti +: Ti]),
      .res_o   (o_nfu2_out[w*N +: N])
    );
  end

endmodule

// File: tb/tb_serial_ip_tile.sv
// Directed, table-driven bench for serial_ip_tile (N=Ti=Tw=16).
module tb_serial_ip_tile;

  logic           clk = 1'b0;
  logic           reset;
  logic           i_start;
  logic           o_ready;
  logic [4:0]     i_precision;
  logic           i_max;
  logic [255:0]   i_synapses;
  logic [255:0]   i_nbout;
  logic           i_bit_valid;
  logic [255:0]   i_neurons;
  logic           o_valid;
  logic           i_out_ready;
  logic [255:0]   o_nfu2_out;

  int n_checks = 0;
  int n_err    = 0;

  serial_ip_tile dut (
    .clk         (clk),
    .reset       (reset),
    .i_start     (i_start),
    .o_ready     (o_ready),
    .i_precision (i_precision),
    .i_max       (i_max),
    .i_synapses  (i_synapses),
    .i_nbout     (i_nbout),
    .i_bit_valid (i_bit_valid),
    .i_neurons   (i_neurons),
    .o_valid     (o_valid),
    .i_out_ready (i_out_ready),
    .o_nfu2_out  (o_nfu2_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          nbits;
    logic [4:0]  prec;
    logic        mx;
    logic [15:0] syn;
    logic [15:0] nb;
    logic [15:0] neu;
    logic [15:0] neu_step;
    logic [15:0] ex;
    logic [15:0] ex_step;
    logic        w3;
    logic [15:0] w3_neu;
    logic [15:0] w3_ex;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(string nm, int nbits, logic [4:0] p, logic mx,
                              logic [15:0] syn, logic [15:0] nb, logic [15:0] neu,
                              logic [15:0] neu_step, logic [15:0] ex, logic [15:0] ex_step,
                              logic w3, logic [15:0] w3_neu, logic [15:0] w3_ex);
    vec_t v;
    v.name = nm; v.nbits = nbits; v.prec = p; v.mx = mx; v.syn = syn; v.nb = nb;
    v.neu = neu; v.neu_step = neu_step; v.ex = ex; v.ex_step = ex_step;
    v.w3 = w3; v.w3_neu = w3_neu; v.w3_ex = w3_ex;
    return v;
  endfunction

  function automatic logic [15:0] neu_of(vec_t v, int w);
    if (v.w3 && w == 3) return v.w3_neu;
    return 16'(v.neu + 16'(w) * v.neu_step);
  endfunction

  function automatic logic [15:0] exp_of(vec_t v, int w);
    if (v.w3 && w == 3) return v.w3_ex;
    return 16'(v.ex + 16'(w) * v.ex_step);
  endfunction

  function automatic logic [255:0] exp_all(vec_t v);
    logic [255:0] r;
    for (int w = 0; w < 16; w++) r[w*16 +: 16] = exp_of(v, w);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bits(input vec_t v, input int b);
    logic [15:0] nv;
    for (int w = 0; w < 16; w++) begin
      nv = neu_of(v, w);
      for (int i = 0; i < 16; i++) i_neurons[w*16 + i] = nv[b];
    end
  endtask

  task automatic load_start(input vec_t v);
    i_precision = v.prec;
    i_max       = v.mx;
    i_synapses  = {16{v.syn}};
    i_nbout     = {16{v.nb}};
    i_start     = 1'b1;
  endtask

  // Full transaction: start, bits (with optional stalls), result, hold, handshake.
  task automatic do_run(input vec_t v, input int stall_a, input int stall_b,
                        input int exp_vcyc, input int hold);
    int cyc;
    int sent;
    logic [255:0] ea;
    ea = exp_all(v);
    load_start(v);
    chk({v.name, "_ready_c0"}, o_ready, 1);
    step();
    i_start = 1'b0;
    cyc = 1;
    sent = 0;
    while (sent < v.nbits && cyc < 100) begin
      chk({v.name, "_ready_busy"}, o_ready, 0);
      if (cyc == stall_a || cyc == stall_b) begin
        i_bit_valid = 1'b0;
        i_neurons   = '1;
      end else begin
        i_bit_valid = 1'b1;
        set_bits(v, v.nbits - 1 - sent);
        sent++;
      end
      step();
      cyc++;
    end
    i_bit_valid = 1'b0;
    i_neurons   = '0;
    while (!o_valid && cyc < 100) begin
      step();
      cyc++;
    end
    chk({v.name, "_valid_cycle"}, cyc, exp_vcyc);
    chk({v.name, "_valid"}, o_valid, 1);
    chk({v.name, "_ready_out"}, o_ready, 0);
    for (int w = 0; w < 16; w++)
      chk($sformatf("%s_w%0d", v.name, w), o_nfu2_out[w*16 +: 16], exp_of(v, w));
    for (int h = 0; h < hold; h++) begin
      load_start(vecs[0]);
      step();
      chk({v.name, "_hold_valid"}, o_valid, 1);
      chk({v.name, "_hold_data"}, o_nfu2_out === ea, 1);
    end
    i_out_ready = 1'b1;
    step();
    i_out_ready = 1'b0;
    i_start     = 1'b0;
    chk({v.name, "_ready_after"}, o_ready, 1);
    chk({v.name, "_valid_after"}, o_valid, 0);
    chk({v.name, "_data_after"}, o_nfu2_out === ea, 1);
  endtask

  initial begin
    vecs[0]  = mk("base",     5,  5'd5,  1'b0, 16'd37,     16'h0000, 16'd10,     16'd0, 16'h1720, 16'd0,  1'b0, 16'd0, 16'h0000);
    vecs[1]  = mk("max_big",  5,  5'd5,  1'b1, 16'd37,     16'h2000, 16'd10,     16'd0, 16'h2000, 16'd0,  1'b0, 16'd0, 16'h0000);
    vecs[2]  = mk("max_neg",  5,  5'd5,  1'b1, 16'd37,     16'hFFFB, 16'd10,     16'd0, 16'h1720, 16'd0,  1'b0, 16'd0, 16'h0000);
    vecs[3]  = mk("max_w3z",  5,  5'd5,  1'b1, 16'd37,     16'hFFFB, 16'd10,     16'd0, 16'h1720, 16'd0,  1'b1, 16'd0, 16'h0000);
    vecs[4]  = mk("sat_pos",  16, 5'd16, 1'b0, 16'h7FFF,   16'h0000, 16'hFFFF,   16'd0, 16'h7FFF, 16'd0,  1'b0, 16'd0, 16'h0000);
    vecs[5]  = mk("sat_neg",  16, 5'd16, 1'b0, 16'h8000,   16'h0000, 16'hFFFF,   16'd0, 16'h8000, 16'd0,  1'b0, 16'd0, 16'h0000);
    vecs[6]  = mk("p0_full",  16, 5'd0,  1'b0, 16'h7FFF,   16'h0000, 16'hFFFF,   16'd0, 16'h7FFF, 16'd0,  1'b0, 16'd0, 16'h0000);
    vecs[7]  = mk("per_win",  5,  5'd5,  1'b0, 16'd1,      16'h0000, 16'd0,      16'd1, 16'h0000, 16'd16, 1'b0, 16'd0, 16'h0000);
    vecs[8]  = mk("sum_neg",  5,  5'd5,  1'b0, 16'd37,     16'hFFFB, 16'd10,     16'd0, 16'h171B, 16'd0,  1'b0, 16'd0, 16'h0000);
    vecs[9]  = mk("p20_full", 16, 5'd20, 1'b0, 16'd1,      16'h0000, 16'd3,      16'd0, 16'h0030, 16'd0,  1'b0, 16'd0, 16'h0000);
    vecs[10] = mk("p1",       1,  5'd1,  1'b0, 16'd37,     16'h0000, 16'd1,      16'd0, 16'h0250, 16'd0,  1'b0, 16'd0, 16'h0000);

    reset = 1'b1; i_start = 1'b0; i_precision = '0; i_max = 1'b0; i_synapses = '0;
    i_nbout = '0; i_bit_valid = 1'b0; i_neurons = '0; i_out_ready = 1'b0;
    step(); step(); step();
    chk("rst_ready", o_ready, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_nfu2_out === 256'd0, 1);
    reset = 1'b0;
    step();

    for (int k = 0; k < 11; k++) do_run(vecs[k], -1, -1, vecs[k].nbits + 2, 0);

    // Bit stalls at cycles 2 and 3, then output backpressure with start attempts.
    do_run(vecs[0], 2, 3, 9, 0);
    do_run(vecs[0], -1, -1, 7, 4);

    // Reset in the middle of SHIFT, with a previous result still registered.
    load_start(vecs[0]);
    step();
    i_start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      i_bit_valid = 1'b1;
      set_bits(vecs[0], 5 - c);
      if (c == 3) reset = 1'b1;
      step();
    end
    reset = 1'b0;
    i_bit_valid = 1'b0;
    chk("midrst_ready", o_ready, 1);
    chk("midrst_valid", o_valid, 0);
    chk("midrst_data", o_nfu2_out === 256'd0, 1);
    do_run(vecs[0], -1, -1, 7, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/serial_ip_tile.md
# serial_ip_tile

Multi-window, bit-serial inner-product tile for the Stripes datapath. It computes Tw parallel dot products. Each uses a shared Ti-wide synapse vector and per-window bit-serial neurons of programmable precision (MSB first). Results are merged with nbout by sum or max, saturated to N bits, and returned over a valid/ready handshake. It is the parametrised successor of the single-window serial IP pipe and sits between the neuron-buffer serializer and NBout.

## Interface
- N, 16: synapse/output width (signed two's complement)
- Ti, 16: synapse lanes per window
- Tw, 16: windows processed in parallel
- PW, $clog2(N)+1: precision field width
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- i_start  in  1  request new inner product; accepted only when o_ready=1
- o_ready  out  1  high only in IDLE
- i_precision  in  PW  neuron bit count P, sampled on start; 0 or >N treated as N
- i_max  in  1  sampled on start: 0 = sum with nbout, 1 = signed max with nbout
- i_synapses  in  Ti*N  lane i at [i*N +: N], sampled on start
- i_nbout  in  Tw*N  window w at [w*N +: N], sampled on start
- i_bit_valid  in  1  current neuron bit slice valid
- i_neurons  in  Tw*Ti  bit for window w, lane i at [w*Ti+i]; unsigned neurons, MSB first
- o_valid  out  1  results valid; held until i_out_ready
- i_out_ready  in  1  consumer accepts results
- o_nfu2_out  out  Tw*N  saturated results, window w at [w*N +: N]

## Operation
- States: IDLE, SHIFT, FINAL, OUT.
- IDLE: on i_start, latch P, mode, synapses and nbout. Clear all accumulators and bit counter. Go to SHIFT.
- SHIFT: bits are not accepted in the start cycle. Each cycle with i_bit_valid=1, per window w: acc_w <= (acc_w <<< 1) + Σ_i (i_neurons[w*Ti+i] ? sext(syn_i) : 0), and cnt++. With i_bit_valid=0 the cycle holds all state (stall). After the P-th accepted bit go to FINAL.
- FINAL: res_w = sum mode ? acc_w + sext(nbout_w) : (acc_w > sext(nbout_w) ? acc_w : sext(nbout_w)). The comparison is signed. Saturate to [-2^(N-1), 2^(N-1)-1] and register into o_nfu2_out. Set o_valid. Go to OUT.
- OUT: hold o_valid and o_nfu2_out stable. When i_out_ready=1, clear o_valid and go to IDLE. i_start is ignored in this cycle because o_ready=0.
- Accumulator width ACC_W = 2N + clog2(Ti) + 1. No internal overflow is possible for P ≤ N.
- i_start outside IDLE is ignored. i_neurons and i_bit_valid outside SHIFT are ignored.
- Reset (any state, including mid-SHIFT or OUT) forces the following, with no partial result emitted:
  - IDLE
  - o_ready=1
  - o_valid=0
  - o_nfu2_out=0
  - accumulators=0
  - counter=0

## Timing
- Reset values: o_ready=1, o_valid=0, o_nfu2_out=0.
- Start accepted at cycle 0. Bits are accepted on cycles 1..P when there are no stalls. FINAL occupies cycle P+1. o_valid is high from cycle P+2.
- With S stall cycles, o_valid rises at cycle P+S+2.
- An output handshake at cycle k puts o_ready=1 at k+1. Minimum start-to-start interval is P+3.
- o_nfu2_out changes only on the FINAL→OUT transition or reset.

## Structure
- stripes_pkg holds:
  - the state enum
  - the ACC_W function
  - the signed saturate function (ACC_W→N)
  - the precision clamp helper
- Sub-module serial_ip_lane is instantiated Tw times. It contains one window's Ti-input gated adder tree, shift-accumulator and FINAL merge/saturate.
- The tile owns the FSM, bit counter, operand latches and handshake.

## Test plan
- N=Ti=Tw=16, every window's neuron = 10 (P=5, bits 01010), all synapses 37, nbout=0, sum mode → every window = 0x1720. o_valid at cycle 7; o_ready low during cycles 1–7.
- Same stimulus, max mode: nbout=0x2000 → 0x2000; nbout=0xFFFB (-5) → 0x1720; window 3 with neuron 0 and nbout 0xFFFB → 0x0000.
- Saturation: synapses 0x7FFF, neuron 0xFFFF, P=16 → 0x7FFF. Synapses 0x8000 → 0x8000. P=0 behaves identically to P=16.
- Stalls/backpressure: baseline case with i_bit_valid low at cycles 2 and 3 → 0x1720 with o_valid at cycle 9. i_out_ready held low 4 cycles → outputs stable. i_start during OUT ignored.
- Reset asserted in SHIFT cycle 3 → next cycle o_ready=1, o_valid=0, o_nfu2_out=0. A fresh baseline run afterwards yields 0x1720 with no residue.
- Per-window independence: window w uses neuron value w, all synapses 1, P=5 → window w result = 16·w.
